regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 14 +
 rtl/sb_counter.sv | 48 ++++
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and bus-slicing helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DefXlen     = 32;
  localparam int unsigned DefRegNum   = 32;
  localparam int unsigned DefAddrSize = 5;
  localparam int unsigned DefCntBits  = 2;

  // Low bit of port `port` inside a flattened bus of `width`-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one register: +inc, -dec, clamped to [0, 2^CntBits-1].
module sb_counter #(
  parameter int unsigned CntBits = 2,
  parameter int unsigned DecW    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic [DecW-1:0]    dec,
  input  logic               clear,
  output logic [CntBits-1:0] count,
  output logic               sat
);

  localparam int unsigned SumW = CntBits + DecW + 1;
  localparam logic [SumW-1:0] Max = SumW'((1 << CntBits) - 1);

  logic [CntBits-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]    up, down;

  assign up   = SumW'(cnt_q) + SumW'(inc);
  assign down = SumW'(dec);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (up <= down) begin
      cnt_d = '0;
    end else if ((up - down) > Max) begin
      cnt_d = '1;
    end else begin
      cnt_d = CntBits'(up - down);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign sat   = (cnt_q == '1);

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a per-register
// pending-write scoreboard that stalls issue on RAW hazards and counter saturation.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = DefXlen,
  parameter int unsigned REG_NUM   = DefRegNum,
  parameter int unsigned ADDR_SIZE = DefAddrSize,
  parameter int unsigned RD_PORTS  = 2,
  parameter int unsigned WR_PORTS  = 1,
  parameter int unsigned CNT_BITS  = DefCntBits
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RD_PORTS*ADDR_SIZE-1:0] R_addr,
  input  logic [RD_PORTS-1:0]           R_use,
  output logic [RD_PORTS*XLEN-1:0]      R_data,
  input  logic [WR_PORTS-1:0]           WB_we,
  input  logic [WR_PORTS*ADDR_SIZE-1:0] WB_rd,
  input  logic [WR_PORTS*XLEN-1:0]      WB_data,
  input  logic                          I_valid,
  input  logic                          I_we,
  input  logic [ADDR_SIZE-1:0]          I_rd,
  input  logic                          flush,
  output logic                          I_stall,
  output logic [REG_NUM-1:0]            busy
);

  localparam int unsigned DecW = $clog2(WR_PORTS + 1);

  logic [XLEN-1:0]      regs_q  [REG_NUM];
  logic [ADDR_SIZE-1:0] wb_idx  [WR_PORTS];
  logic [XLEN-1:0]      wb_val  [WR_PORTS];
  logic [ADDR_SIZE-1:0] rd_idx  [RD_PORTS];
  logic [DecW-1:0]      hits    [REG_NUM];
  logic [CNT_BITS-1:0]  cnt     [REG_NUM];
  logic                 sat_a   [REG_NUM];
  logic                 inc_a   [REG_NUM];
  logic                 stall_raw;
  logic                 issue_fire;

  for (genvar w = 0; w < WR_PORTS; w++) begin : g_wb
    assign wb_idx[w] = WB_rd[slice_lo(w, ADDR_SIZE) +: ADDR_SIZE];
    assign wb_val[w] = WB_data[slice_lo(w, XLEN) +: XLEN];
  end

  // Number of writeback ports retiring each register this cycle.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      hits[r] = '0;
      for (int w = 0; w < WR_PORTS; w++) begin
        if (WB_we[w] && (wb_idx[w] == ADDR_SIZE'(r))) hits[r] = hits[r] + DecW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) regs_q[r] <= '0;
    end else begin
      // Later ports override earlier ones on a shared index.
      for (int w = 0; w < WR_PORTS; w++) begin
        if (WB_we[w] && (wb_idx[w] != '0)) regs_q[wb_idx[w]] <= wb_val[w];
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [XLEN-1:0] val;
    assign rd_idx[p] = R_addr[slice_lo(p, ADDR_SIZE) +: ADDR_SIZE];
    always_comb begin
      val = regs_q[rd_idx[p]];
      for (int w = 0; w < WR_PORTS; w++) begin
        if (WB_we[w] && (wb_idx[w] == rd_idx[p])) val = wb_val[w];
      end
      if (rd_idx[p] == '0 || rst) val = '0;
    end
    assign R_data[slice_lo(p, XLEN) +: XLEN] = val;
  end

  always_comb begin
    stall_raw = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (R_use[p] && (rd_idx[p] != '0) &&
          (32'(cnt[rd_idx[p]]) > 32'(hits[rd_idx[p]]))) stall_raw = 1'b1;
    end
    if (I_we && (I_rd != '0) && sat_a[I_rd] && (hits[I_rd] == '0)) stall_raw = 1'b1;
  end

  assign I_stall    = I_valid & ~rst & stall_raw;
  assign issue_fire = I_valid & I_we & ~I_stall & (I_rd != '0);

  assign cnt[0]   = '0;
  assign sat_a[0] = 1'b0;
  assign inc_a[0] = 1'b0;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
    assign inc_a[r] = issue_fire & (I_rd == ADDR_SIZE'(r));
    sb_counter #(
      .CntBits (CNT_BITS),
      .DecW    (DecW)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_a[r]),
      .dec   (hits[r]),
      .clear (flush),
      .count (cnt[r]),
      .sat   (sat_a[r])
    );
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < REG_NUM; r++) busy[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic
// compared against an array-based reference model of the scoreboard.
module tb_regfile_sb;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam int CB = 2;
  localparam int CMAX = (1 << CB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] ra      [RP];
  logic [RP-1:0] r_use;
  logic [WP-1:0] wb_we;
  logic [AW-1:0] wb_rd   [WP];
  logic [XL-1:0] wb_data [WP];
  logic          i_valid, i_we, flush;
  logic [AW-1:0] i_rd;
  logic          i_stall;
  logic [NR-1:0] busy;

  logic [RP*AW-1:0] ra_bus;
  logic [RP*XL-1:0] rdata_bus;
  logic [WP*AW-1:0] wbrd_bus;
  logic [WP*XL-1:0] wbdata_bus;

  assign ra_bus     = {ra[1], ra[0]};
  assign wbrd_bus   = {wb_rd[1], wb_rd[0]};
  assign wbdata_bus = {wb_data[1], wb_data[0]};

  regfile_sb #(
    .XLEN      (XL),
    .REG_NUM   (NR),
    .ADDR_SIZE (AW),
    .RD_PORTS  (RP),
    .WR_PORTS  (WP),
    .CNT_BITS  (CB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .R_addr  (ra_bus),
    .R_use   (r_use),
    .R_data  (rdata_bus),
    .WB_we   (wb_we),
    .WB_rd   (wbrd_bus),
    .WB_data (wbdata_bus),
    .I_valid (i_valid),
    .I_we    (i_we),
    .I_rd    (i_rd),
    .flush   (flush),
    .I_stall (i_stall),
    .busy    (busy)
  );

  logic [XL-1:0] mregs [NR];
  int            mcnt  [NR];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    for (int p = 0; p < RP; p++) ra[p] = '0;
    r_use = '0;
    wb_we = '0;
    for (int w = 0; w < WP; w++) begin
      wb_rd[w]   = '0;
      wb_data[w] = '0;
    end
    i_valid = 1'b0;
    i_we    = 1'b0;
    i_rd    = '0;
    flush   = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mregs[r] = '0;
      mcnt[r]  = 0;
    end
  endtask

  // Check combinational outputs against the model, then advance one edge.
  task automatic cycle(input string tag);
    int            hits [NR];
    bit            exp_stall;
    logic [XL-1:0] exp_rd;
    logic [NR-1:0] exp_busy;
    #1;
    for (int r = 0; r < NR; r++) hits[r] = 0;
    for (int w = 0; w < WP; w++) if (wb_we[w]) hits[wb_rd[w]]++;
    exp_stall = 1'b0;
    if (i_valid) begin
      for (int p = 0; p < RP; p++)
        if (r_use[p] && ra[p] != 0 && mcnt[ra[p]] > hits[ra[p]]) exp_stall = 1'b1;
      if (i_we && i_rd != 0 && mcnt[i_rd] == CMAX && hits[i_rd] == 0) exp_stall = 1'b1;
    end
    chk($sformatf("%s_stall", tag), 64'(i_stall), 64'(exp_stall));
    for (int p = 0; p < RP; p++) begin
      exp_rd = mregs[ra[p]];
      for (int w = 0; w < WP; w++) if (wb_we[w] && wb_rd[w] == ra[p]) exp_rd = wb_data[w];
      if (ra[p] == 0) exp_rd = '0;
      chk($sformatf("%s_rdata%0d", tag, p), 64'(rdata_bus[p*XL +: XL]), 64'(exp_rd));
    end
    for (int r = 0; r < NR; r++) exp_busy[r] = (mcnt[r] != 0);
    chk($sformatf("%s_busy", tag), 64'(busy), 64'(exp_busy));
    @(posedge clk);
    for (int w = 0; w < WP; w++) if (wb_we[w] && wb_rd[w] != 0) mregs[wb_rd[w]] = wb_data[w];
    for (int r = 1; r < NR; r++) begin
      if (flush) begin
        mcnt[r] = 0;
      end else begin
        mcnt[r] += ((i_valid && i_we && !exp_stall && i_rd == r) ? 1 : 0) - hits[r];
        if (mcnt[r] < 0) mcnt[r] = 0;
      end
    end
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall", 64'(i_stall), 64'(0));
    chk("rst_rdata", 64'(rdata_bus), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle write-through, then persistent value.
    wb_we[0] = 1'b1; wb_rd[0] = 5'd5; wb_data[0] = 32'h1234; ra[0] = 5'd5;
    cycle("wt_same");
    chk("wt_x5_now", 64'(rdata_bus[31:0]), 64'h1234);
    idle(); ra[0] = 5'd5; ra[1] = 5'd0;
    cycle("wt_later");
    chk("wt_x5_later", 64'(rdata_bus[31:0]), 64'h1234);

    // RAW hazard on x7 released by a same-cycle writeback.
    idle(); i_valid = 1'b1; i_we = 1'b1; i_rd = 5'd7;
    cycle("raw_issue");
    idle(); i_valid = 1'b1; r_use = 2'b01; ra[0] = 5'd7;
    #1; chk("raw_stall_hi", 64'(i_stall), 64'(1));
    cycle("raw_wait");
    wb_we[0] = 1'b1; wb_rd[0] = 5'd7; wb_data[0] = 32'hBEEF;
    #1; chk("raw_stall_lo", 64'(i_stall), 64'(0));
    cycle("raw_retire");

    // Counter saturation on x3.
    for (int k = 0; k < 3; k++) begin
      idle(); i_valid = 1'b1; i_we = 1'b1; i_rd = 5'd3;
      cycle("sat_issue");
    end
    #1;
    chk("sat_stall", 64'(i_stall), 64'(1));
    chk("sat_busy3", 64'(busy[3]), 64'(1));
    cycle("sat_blocked");
    idle(); wb_we[0] = 1'b1; wb_rd[0] = 5'd3; wb_data[0] = 32'h33;
    cycle("sat_retire");
    idle(); i_valid = 1'b1; i_we = 1'b1; i_rd = 5'd3;
    #1; chk("sat_accept", 64'(i_stall), 64'(0));
    cycle("sat_reissue");
    idle(); flush = 1'b1;
    cycle("sat_flush");

    // Dual writeback to x9: highest port wins, counter 2 -> 0.
    for (int k = 0; k < 2; k++) begin
      idle(); i_valid = 1'b1; i_we = 1'b1; i_rd = 5'd9;
      cycle("dual_issue");
    end
    idle();
    wb_we = 2'b11; wb_rd[0] = 5'd9; wb_rd[1] = 5'd9; wb_data[0] = 32'hA; wb_data[1] = 32'hB;
    ra[0] = 5'd9;
    cycle("dual_wb");
    idle(); ra[0] = 5'd9;
    cycle("dual_after");
    chk("dual_x9", 64'(rdata_bus[31:0]), 64'hB);
    chk("dual_busy9", 64'(busy[9]), 64'(0));

    // Flush with a concurrent writeback.
    for (int k = 0; k < 3; k++) begin
      idle(); i_valid = 1'b1; i_we = 1'b1; i_rd = (k == 2) ? 5'd6 : 5'd4;
      cycle("fl_issue");
    end
    idle(); flush = 1'b1; wb_we[0] = 1'b1; wb_rd[0] = 5'd4; wb_data[0] = 32'h55;
    cycle("fl_flush");
    idle(); ra[0] = 5'd4;
    cycle("fl_after");
    chk("fl_busy", 64'(busy), 64'(0));
    chk("fl_x4", 64'(rdata_bus[31:0]), 64'h55);

    // Asynchronous reset between edges.
    idle(); i_valid = 1'b1; i_we = 1'b1; i_rd = 5'd2;
    cycle("ar_issue");
    idle(); i_valid = 1'b1; r_use = 2'b11; ra[0] = 5'd2; ra[1] = 5'd5;
    wb_we[0] = 1'b1; wb_rd[0] = 5'd5; wb_data[0] = 32'hFACE;
    #1;
    rst = 1'b1;
    #1;
    chk("ar_rdata", 64'(rdata_bus), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_stall", 64'(i_stall), 64'(0));
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic on a narrow index range to force collisions.
    for (int k = 0; k < 400; k++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_we    = 1'($urandom_range(0, 1));
      i_rd    = AW'($urandom_range(0, 7));
      for (int p = 0; p < RP; p++) ra[p] = AW'($urandom_range(0, 7));
      r_use = RP'($urandom);
      for (int w = 0; w < WP; w++) begin
        wb_we[w]   = ($urandom_range(0, 3) == 0);
        wb_rd[w]   = AW'($urandom_range(0, 7));
        wb_data[w] = $urandom;
      end
      flush = ($urandom_range(0, 31) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
